e_mdu: RTL and testbench

- Multiply/divide unit in the E stage, operating beside E_ALU.
- Takes the same forwarded operands as the ALU (rs/rt values after bypass muxes).
- Owns the architectural HI/LO registers and runs MULT/MULTU/DIV/DIVU as multi-cycle operations.
- Serves MFHI/MFLO reads into the E-stage result mux and exports a busy indication to the hazard/stall unit.

---
 rtl/e_mdu.sv | 134 +++++++++++++
 tb/tb_e_mdu.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO, runs MULT/MULTU/DIV/DIVU over a
// fixed cycle count and serves MFHI/MFLO/MTHI/MTLO.
// Ports: clk, reset (async active-low), E_MDUA/E_MDUB operands, E_MDUOp op code,
//        E_MDURe read data, E_MDUBusy (registered), E_MDUStart (combinational).
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] E_MDUA,
  input  logic [31:0] E_MDUB,
  input  logic [3:0]  E_MDUOp,
  output logic [31:0] E_MDURe,
  output logic        E_MDUBusy,
  output logic        E_MDUStart
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_phi;
  logic [31:0]   r_plo;
  logic          r_wr;
  logic          r_busy;
  logic [CW-1:0] r_cnt;

  logic          w_mul;
  logic          w_div;
  logic          w_sgn;
  logic          w_mthi;
  logic          w_mtlo;
  logic [63:0]   w_ps;
  logic [63:0]   w_pu;
  logic [31:0]   w_na;
  logic [31:0]   w_nb;
  logic [31:0]   w_q;
  logic [31:0]   w_r;
  logic [31:0]   w_dq;
  logic [31:0]   w_dr;
  logic [31:0]   w_hi;
  logic [31:0]   w_lo;

  assign w_mul = (E_MDUOp == OP_MULT) || (E_MDUOp == OP_MULTU);
  assign w_div = (E_MDUOp == OP_DIV)  || (E_MDUOp == OP_DIVU);
  assign w_sgn = (E_MDUOp == OP_DIV);
  assign w_mthi = (E_MDUOp == OP_MTHI);
  assign w_mtlo = (E_MDUOp == OP_MTLO);

  assign E_MDUStart = (w_mul || w_div) && !r_busy;
  assign E_MDUBusy  = r_busy;

  // Low 64 bits of sign-/zero-extended products give the exact result.
  assign w_ps = {{32{E_MDUA[31]}}, E_MDUA} * {{32{E_MDUB[31]}}, E_MDUB};
  assign w_pu = {32'd0, E_MDUA} * {32'd0, E_MDUB};

  // Signed divide on magnitudes: avoids the INT_MIN / -1 overflow case and
  // lets truncation toward zero fall out of the unsigned divide.
  assign w_na = (w_sgn && E_MDUA[31]) ? (32'd0 - E_MDUA) : E_MDUA;
  assign w_nb = (w_sgn && E_MDUB[31]) ? (32'd0 - E_MDUB) : E_MDUB;
  assign w_q  = (w_nb != 32'd0) ? (w_na / w_nb) : 32'd0;
  assign w_r  = (w_nb != 32'd0) ? (w_na % w_nb) : 32'd0;
  assign w_dq = (w_sgn && (E_MDUA[31] ^ E_MDUB[31])) ? (32'd0 - w_q) : w_q;
  assign w_dr = (w_sgn && E_MDUA[31]) ? (32'd0 - w_r) : w_r;

  always_comb begin
    w_hi = 32'd0;
    w_lo = 32'd0;
    case (E_MDUOp)
      OP_MULT:  begin w_hi = w_ps[63:32]; w_lo = w_ps[31:0]; end
      OP_MULTU: begin w_hi = w_pu[63:32]; w_lo = w_pu[31:0]; end
      OP_DIV,
      OP_DIVU:  begin w_hi = w_dr; w_lo = w_dq; end
      default:  ;
    endcase
  end

  always_comb begin
    E_MDURe = 32'd0;
    case (E_MDUOp)
      OP_MFHI: E_MDURe = r_hi;
      OP_MFLO: E_MDURe = r_lo;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hi   <= 32'd0;
      r_lo   <= 32'd0;
      r_phi  <= 32'd0;
      r_plo  <= 32'd0;
      r_wr   <= 1'b0;
      r_busy <= 1'b0;
      r_cnt  <= '0;
    end else if (r_busy) begin
      r_cnt <= r_cnt - CW'(1);
      if (r_cnt == CW'(1)) begin
        r_busy <= 1'b0;
        // Divide by zero completes without touching HI/LO.
        if (r_wr) begin
          r_hi <= r_phi;
          r_lo <= r_plo;
        end
      end
    end else begin
      unique case (1'b1)
        w_mul, w_div: begin
          r_phi  <= w_hi;
          r_plo  <= w_lo;
          r_wr   <= !(w_div && (E_MDUB == 32'd0));
          r_busy <= 1'b1;
          r_cnt  <= w_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        end
        w_mthi: r_hi <= E_MDUA;
        w_mtlo: r_lo <= E_MDUA;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: directed vector table, hand sequences for busy/reset
// corner cases, and randomized ops checked against an arithmetic model.
module tb_e_mdu;

  logic        clk;
  logic        reset;
  logic [31:0] E_MDUA;
  logic [31:0] E_MDUB;
  logic [3:0]  E_MDUOp;
  logic [31:0] E_MDURe;
  logic        E_MDUBusy;
  logic        E_MDUStart;

  int n_tests;
  int n_fail;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .E_MDUA     (E_MDUA),
    .E_MDUB     (E_MDUB),
    .E_MDUOp    (E_MDUOp),
    .E_MDURe    (E_MDURe),
    .E_MDUBusy  (E_MDUBusy),
    .E_MDUStart (E_MDUStart)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi,
                           input logic [31:0] lo);
    E_MDUOp = 4'd5;
    #1 check({tag, " hi"}, E_MDURe, hi);
    E_MDUOp = 4'd6;
    #1 check({tag, " lo"}, E_MDURe, lo);
    E_MDUOp = 4'd0;
    #1;
  endtask

  // Called at a negedge; returns at a negedge with the unit idle.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int cyc, input logic [31:0] hi,
                        input logic [31:0] lo);
    int n;
    E_MDUOp = op;
    E_MDUA  = a;
    E_MDUB  = b;
    #1 check({tag, " start"}, 32'(E_MDUStart), 32'(op >= 4'd1 && op <= 4'd4));
    @(posedge clk);
    @(negedge clk);
    E_MDUOp = 4'd0;
    n = 0;
    while (E_MDUBusy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, " busy cycles"}, 32'(n), 32'(cyc));
    read_hilo(tag, hi, lo);
  endtask

  // Reference model from the arithmetic definitions.
  task automatic model(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output int cyc);
    longint sa, sb, q, r;
    longint unsigned ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    cyc = 0;
    case (op)
      4'd1: begin
        q = sa * sb;
        m_hi = q[63:32]; m_lo = q[31:0]; cyc = 5;
      end
      4'd2: begin
        p = ua * ub;
        m_hi = p[63:32]; m_lo = p[31:0]; cyc = 5;
      end
      4'd3: begin
        cyc = 10;
        if (b != 0) begin
          q = sa / sb; r = sa % sb;
          m_hi = r[31:0]; m_lo = q[31:0];
        end
      end
      4'd4: begin
        cyc = 10;
        if (b != 0) begin
          p = ua / ub; m_lo = p[31:0];
          p = ua % ub; m_hi = p[31:0];
        end
      end
      4'd7: m_hi = a;
      4'd8: m_lo = a;
      default: ;
    endcase
  endtask

  vec_t vt[10];

  initial begin
    int n;
    int cyc;
    logic [3:0]  op;
    logic [31:0] a, b;

    n_tests = 0;
    n_fail  = 0;

    vt[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vt[1] = '{4'd2, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 5};
    vt[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vt[3] = '{4'd4, 32'd7, 32'd2, 32'd1, 32'd3, 10};
    vt[4] = '{4'd7, 32'h12345678, 32'd0, 32'h12345678, 32'd3, 0};
    vt[5] = '{4'd8, 32'h9ABCDEF0, 32'd0, 32'h12345678, 32'h9ABCDEF0, 0};
    vt[6] = '{4'd3, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10};
    vt[7] = '{4'd4, 32'd5, 32'd0, 32'h12345678, 32'h9ABCDEF0, 10};
    vt[8] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10};
    vt[9] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 5};

    reset   = 1'b0;
    E_MDUOp = 4'd0;
    E_MDUA  = 32'd0;
    E_MDUB  = 32'd0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(E_MDUBusy), 32'd0);
    read_hilo("reset", 32'd0, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post-reset busy", 32'(E_MDUBusy), 32'd0);
    read_hilo("post-reset", 32'd0, 32'd0);

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b,
             vt[i].cyc, vt[i].hi, vt[i].lo);

    // Ops issued while busy are ignored; MFLO sees the old LO.
    run_op("pre-mtlo", 4'd8, 32'h11111111, 32'd0, 0, 32'h40000000,
           32'h11111111);
    E_MDUOp = 4'd1;
    E_MDUA  = 32'hFFFFFFFE;
    E_MDUB  = 32'd3;
    @(posedge clk);
    @(negedge clk);
    n = 0;
    while (E_MDUBusy && n < 100) begin
      n++;
      case (n)
        1: begin
          E_MDUOp = 4'd6;
          #1 check("mflo while busy", E_MDURe, 32'h11111111);
        end
        2: begin
          E_MDUOp = 4'd1; E_MDUA = 32'd7; E_MDUB = 32'd7;
          #1 check("start while busy", 32'(E_MDUStart), 32'd0);
        end
        3: E_MDUOp = 4'd8;
        default: E_MDUOp = 4'd0;
      endcase
      @(negedge clk);
    end
    E_MDUOp = 4'd0;
    check("busy-ign cycles", 32'(n), 32'd5);
    read_hilo("busy-ign", 32'hFFFFFFFF, 32'hFFFFFFFA);

    // Reset during a divide aborts it for good.
    run_op("pre-mthi", 4'd7, 32'hAAAA5555, 32'd0, 0, 32'hAAAA5555,
           32'hFFFFFFFA);
    E_MDUOp = 4'd3;
    E_MDUA  = 32'd100;
    E_MDUB  = 32'd7;
    @(posedge clk);
    @(negedge clk);
    E_MDUOp = 4'd0;
    repeat (2) @(negedge clk);
    check("busy before abort", 32'(E_MDUBusy), 32'd1);
    reset = 1'b0;
    #1 check("abort busy", 32'(E_MDUBusy), 32'd0);
    read_hilo("abort", 32'd0, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (15) @(negedge clk);
    check("after abort busy", 32'(E_MDUBusy), 32'd0);
    read_hilo("after abort", 32'd0, 32'd0);

    // Randomized ops against the model.
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      op = 4'($urandom_range(1, 8));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 9));
      model(op, a, b, cyc);
      run_op($sformatf("rnd%0d op%0d", i, op), op, a, b, cyc, m_hi, m_lo);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
